// File: rtl/bank_request_fifo_if.sv
// Handshake bundle between the address mapper / per-bank schedulers and the
// per-bank request buffer. The buffer side uses the slave modport.
interface bank_request_fifo_if #(
  parameter int NUM_BANKS = 16,
  parameter int DEPTH     = 4,
  parameter int REQ_W     = 64,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = $clog2(DEPTH + 1)
);
  logic                         flush;
  logic [NUM_BANKS-1:0]         in_valid;
  logic [REQ_W-1:0]             in_req;
  logic [IDX_W-1:0]             in_index;
  logic [NUM_BANKS-1:0]         busy;
  logic [NUM_BANKS-1:0]         almost_full;
  logic [NUM_BANKS-1:0]         out_valid;
  logic [NUM_BANKS*REQ_W-1:0]   out_req;
  logic [NUM_BANKS*IDX_W-1:0]   out_index;
  logic [NUM_BANKS-1:0]         grant;
  logic [NUM_BANKS*CNT_W-1:0]   count;

  // Mapper/scheduler side: drives pushes, pops and flush.
  modport master (
    output flush, in_valid, in_req, in_index, grant,
    input  busy, almost_full, out_valid, out_req, out_index, count
  );

  // Buffer side.
  modport slave (
    input  flush, in_valid, in_req, in_index, grant,
    output busy, almost_full, out_valid, out_req, out_index, count
  );
endinterface

// File: rtl/bank_request_fifo.sv
// Per-bank request buffer: NUM_BANKS independent first-word-fall-through
// FIFOs sharing one write bus. Each entry holds a request word plus its
// read-table index. Status flags are registered and computed from the
// next-state occupancy, so they carry no combinational path from the
// handshake inputs.
module bank_request_fifo #(
  parameter int NUM_BANKS = 16,
  parameter int DEPTH     = 4,
  parameter int REQ_W     = 64,
  parameter int IDX_W     = 5,
  parameter int AF_MARGIN = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  bank_request_fifo_if.slave bus
);

  localparam int ENTRY_W = REQ_W + IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               valid_r;
    logic               busy_r;
    logic               af_r;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;

    // Accept/pop decision and next occupancy; a full bank still accepts a
    // push when the same cycle pops, since a slot frees up at the edge.
    always_comb begin
      pop_s  = bus.grant[b] & valid_r;
      push_s = bus.in_valid[b] & ((count_r < FULL_CNT) | pop_s);
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end

    // Pointers, occupancy and status flags; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
        count_r  <= CNT_ZERO;
        valid_r  <= 1'b0;
        busy_r   <= 1'b0;
        af_r     <= 1'b0;
      end else if (bus.flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
        count_r  <= CNT_ZERO;
        valid_r  <= 1'b0;
        busy_r   <= 1'b0;
        af_r     <= 1'b0;
      end else begin
        wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        count_r  <= count_nxt_s;
        valid_r  <= (count_nxt_s != CNT_ZERO);
        busy_r   <= (count_nxt_s == FULL_CNT);
        af_r     <= (count_nxt_s >= AF_CNT);
      end
    end

    // Entry storage; deliberately not reset, contents only matter while valid.
    always_ff @(posedge clk) begin
      if (push_s && !bus.flush) begin
        mem_r[wr_ptr_r] <= {bus.in_index, bus.in_req};
      end
    end

    assign head_s = mem_r[rd_ptr_r];

    assign bus.out_valid[b]                   = valid_r;
    assign bus.busy[b]                        = busy_r;
    assign bus.almost_full[b]                 = af_r;
    assign bus.out_req[b*REQ_W +: REQ_W]      = head_s[REQ_W-1:0];
    assign bus.out_index[b*IDX_W +: IDX_W]    = head_s[ENTRY_W-1:REQ_W];
    assign bus.count[b*CNT_W +: CNT_W]        = count_r;
  end

endmodule

// File: tb/tb_bank_request_fifo.sv
// Directed bench for bank_request_fifo with default parameters
// (16 banks, depth 4, 64-bit requests, 5-bit index, almost-full margin 1).
module tb_bank_request_fifo;

  localparam int NB    = 16;
  localparam int DEPTH = 4;
  localparam int REQ_W = 64;
  localparam int IDX_W = 5;
  localparam int CNT_W = 3;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  bank_request_fifo_if #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .REQ_W(REQ_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) bus_if ();

  bank_request_fifo #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .REQ_W(REQ_W), .IDX_W(IDX_W),
    .AF_MARGIN(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_of(input int b);
    return bus_if.count[b*CNT_W +: CNT_W];
  endfunction

  function automatic logic [REQ_W-1:0] req_of(input int b);
    return bus_if.out_req[b*REQ_W +: REQ_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input int b);
    return bus_if.out_index[b*IDX_W +: IDX_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_valid = 16'hFFFF;
    bus_if.in_req = 64'h55;
    repeat (5) begin
      tick();
      total_cnt++;
      if (bus_if.out_valid !== 16'h0000) $display("FAIL reset_out_valid: got %h expected 0000", bus_if.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.busy !== 16'h0000) $display("FAIL reset_busy: got %h expected 0000", bus_if.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.count !== 48'h0) $display("FAIL reset_count: got %h expected 0", bus_if.count);
      else pass_cnt++;
    end
    bus_if.in_valid = 16'h0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    logic [CNT_W-1:0] exp_cnt [6];
    logic             exp_busy [6];
    logic             exp_af [6];
    exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    exp_busy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_af   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 1; k <= 6; k++) begin
      bus_if.in_valid = 16'h0001;
      bus_if.in_req   = 64'(k);
      bus_if.in_index = 5'(k);
      tick();
      total_cnt++;
      if (cnt_of(0) !== exp_cnt[k-1]) $display("FAIL fill_count push%0d: got %0d expected %0d", k, cnt_of(0), exp_cnt[k-1]);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.busy[0] !== exp_busy[k-1]) $display("FAIL fill_busy push%0d: got %b expected %b", k, bus_if.busy[0], exp_busy[k-1]);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.almost_full[0] !== exp_af[k-1]) $display("FAIL fill_af push%0d: got %b expected %b", k, bus_if.almost_full[0], exp_af[k-1]);
      else pass_cnt++;
    end
    bus_if.in_valid = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      total_cnt++;
      if (req_of(0) !== 64'(k) || bus_if.out_valid[0] !== 1'b1)
        $display("FAIL fill_drain_req %0d: got %0h valid %b expected %0h valid 1", k, req_of(0), bus_if.out_valid[0], k);
      else pass_cnt++;
      total_cnt++;
      if (idx_of(0) !== 5'(k)) $display("FAIL fill_drain_idx %0d: got %0h expected %0h", k, idx_of(0), k);
      else pass_cnt++;
      bus_if.grant = 16'h0001;
      tick();
    end
    bus_if.grant = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid[0] !== 1'b0 || cnt_of(0) !== 3'd0 || bus_if.busy[0] !== 1'b0)
      $display("FAIL fill_empty: got valid %b count %0d busy %b expected 0 0 0", bus_if.out_valid[0], cnt_of(0), bus_if.busy[0]);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    for (int k = 1; k <= 4; k++) begin
      bus_if.in_valid = 16'h0008;
      bus_if.in_req   = 64'(k);
      bus_if.in_index = 5'(k);
      tick();
    end
    total_cnt++;
    if (bus_if.busy[3] !== 1'b1 || req_of(3) !== 64'd1)
      $display("FAIL fullpp_filled: got busy %b head %0h expected 1 1", bus_if.busy[3], req_of(3));
    else pass_cnt++;
    bus_if.in_req   = 64'd5;
    bus_if.in_index = 5'd5;
    bus_if.grant    = 16'h0008;
    tick();
    bus_if.in_valid = 16'h0000;
    bus_if.grant    = 16'h0000;
    total_cnt++;
    if (cnt_of(3) !== 3'd4 || bus_if.busy[3] !== 1'b1 || req_of(3) !== 64'd2)
      $display("FAIL fullpp_same_edge: got count %0d busy %b head %0h expected 4 1 2", cnt_of(3), bus_if.busy[3], req_of(3));
    else pass_cnt++;
    for (int k = 2; k <= 5; k++) begin
      total_cnt++;
      if (req_of(3) !== 64'(k) || bus_if.out_valid[3] !== 1'b1)
        $display("FAIL fullpp_drain %0d: got %0h valid %b expected %0h valid 1", k, req_of(3), bus_if.out_valid[3], k);
      else pass_cnt++;
      bus_if.grant = 16'h0008;
      tick();
    end
    bus_if.grant = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid[3] !== 1'b0) $display("FAIL fullpp_empty: got %b expected 0", bus_if.out_valid[3]);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [REQ_W-1:0] exp_q [$];
    logic [REQ_W-1:0] next_val;
    next_val = 64'd200;
    // prefill one entry so every round runs at occupancy 1..2
    bus_if.in_valid = 16'h0080;
    bus_if.in_req   = next_val;
    exp_q.push_back(next_val);
    next_val++;
    tick();
    for (int r = 0; r < 10; r++) begin
      for (int ph = 0; ph < 3; ph++) begin
        logic do_push;
        logic do_pop;
        do_push = (ph != 2);
        do_pop  = (ph != 0);
        if (do_pop) begin
          total_cnt++;
          if (req_of(7) !== exp_q[0]) $display("FAIL wrap_head r%0d p%0d: got %0h expected %0h", r, ph, req_of(7), exp_q[0]);
          else pass_cnt++;
          void'(exp_q.pop_front());
        end
        bus_if.in_valid = do_push ? 16'h0080 : 16'h0000;
        bus_if.grant    = do_pop  ? 16'h0080 : 16'h0000;
        bus_if.in_req   = next_val;
        if (do_push) begin
          exp_q.push_back(next_val);
          next_val++;
        end
        tick();
        total_cnt++;
        if (cnt_of(7) !== CNT_W'(exp_q.size()) || cnt_of(7) > 3'd2)
          $display("FAIL wrap_count r%0d p%0d: got %0d expected %0d", r, ph, cnt_of(7), exp_q.size());
        else pass_cnt++;
      end
    end
    bus_if.in_valid = 16'h0000;
    bus_if.grant    = 16'h0080;
    tick();
    bus_if.grant    = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid[7] !== 1'b0) $display("FAIL wrap_empty: got %b expected 0", bus_if.out_valid[7]);
    else pass_cnt++;
  endtask

  task automatic test_multi_bank();
    bus_if.in_valid = 16'h8001;
    bus_if.in_req   = 64'hA;
    bus_if.in_index = 5'hA;
    tick();
    bus_if.in_valid = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid !== 16'h8001) $display("FAIL multi_valid: got %h expected 8001", bus_if.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_of(0) !== 64'hA || req_of(15) !== 64'hA || idx_of(15) !== 5'hA)
      $display("FAIL multi_data: got %0h %0h idx %0h expected a a a", req_of(0), req_of(15), idx_of(15));
    else pass_cnt++;
    bus_if.grant = 16'h0020;
    tick();
    bus_if.grant = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid !== 16'h8001 || cnt_of(5) !== 3'd0 || cnt_of(0) !== 3'd1)
      $display("FAIL multi_spurious_grant: got valid %h c5 %0d c0 %0d expected 8001 0 1", bus_if.out_valid, cnt_of(5), cnt_of(0));
    else pass_cnt++;
    bus_if.grant = 16'h8001;
    tick();
    bus_if.grant = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid !== 16'h0000) $display("FAIL multi_drain: got %h expected 0000", bus_if.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    bus_if.in_valid = 16'h000F;
    bus_if.in_req   = 64'h33;
    tick();
    tick();
    total_cnt++;
    if (bus_if.count !== 48'h492)
      $display("FAIL flush_prefill: got %h expected 000000000492", bus_if.count);
    else pass_cnt++;
    bus_if.in_valid = 16'h0001;
    bus_if.flush    = 1'b1;
    tick();
    bus_if.flush    = 1'b0;
    bus_if.in_valid = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid !== 16'h0000 || bus_if.count !== 48'h0 || bus_if.almost_full !== 16'h0000)
      $display("FAIL flush_clear: got valid %h count %h af %h expected 0", bus_if.out_valid, bus_if.count, bus_if.almost_full);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus_if.out_valid[0] !== 1'b0) $display("FAIL flush_push_discard: got %b expected 0", bus_if.out_valid[0]);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bus_if.in_valid = 16'h0004;
    bus_if.in_req   = 64'd77;
    tick();
    bus_if.in_valid = 16'h0000;
    total_cnt++;
    if (bus_if.out_valid[2] !== 1'b1) $display("FAIL arst_pre: got %b expected 1", bus_if.out_valid[2]);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (bus_if.out_valid !== 16'h0000 || bus_if.count !== 48'h0)
      $display("FAIL arst_immediate: got valid %h count %h expected 0", bus_if.out_valid, bus_if.count);
    else pass_cnt++;
    #2 rst = 1'b0;
    tick();
    total_cnt++;
    if (bus_if.out_valid !== 16'h0000) $display("FAIL arst_release: got %h expected 0000", bus_if.out_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    rst             = 1'b1;
    bus_if.flush    = 1'b0;
    bus_if.in_valid = 16'h0000;
    bus_if.in_req   = 64'h0;
    bus_if.in_index = 5'h0;
    bus_if.grant    = 16'h0000;
    test_reset();
    test_fill();
    test_full_push_pop();
    test_wrap();
    test_multi_bank();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bank_request_fifo.md
# bank_request_fifo

Parametrised per-bank request buffer in the memory-controller front end, sitting between the address mapper and the per-bank schedulers. It holds NUM_BANKS independent first-word-fall-through FIFOs, each storing a request word plus its read-table index. Compared with the single-channel request FIFO it adds configurable depth and width, per-bank occupancy and almost-full reporting, simultaneous push/pop at full, and a synchronous flush.

## Interface
- NUM_BANKS, 16, number of independent bank FIFOs (≥1)
- DEPTH, 4, entries per bank FIFO (power of two, ≥2)
- REQ_W, 64, width of the packed request word
- IDX_W, 5, width of the read-table index carried with each request
- AF_MARGIN, 1, almost_full asserts when free entries ≤ AF_MARGIN (0 ≤ AF_MARGIN < DEPTH)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all banks
- in_valid  in  NUM_BANKS  per-bank push request from mapper
- in_req  in  REQ_W  request word (shared bus, written into every bank whose in_valid is high)
- in_index  in  IDX_W  index accompanying in_req
- busy  out  NUM_BANKS  bank full (count == DEPTH)
- almost_full  out  NUM_BANKS  count ≥ DEPTH − AF_MARGIN
- out_valid  out  NUM_BANKS  bank head entry valid
- out_req  out  NUM_BANKS×REQ_W  head request per bank (bank b at bits [b*REQ_W +: REQ_W])
- out_index  out  NUM_BANKS×IDX_W  head index per bank
- grant  in  NUM_BANKS  per-bank pop from scheduler
- count  out  NUM_BANKS×CNT_W  per-bank occupancy

## Operation
- Each bank: circular buffer of DEPTH entries, write pointer, read pointer and occupancy counter; pointers log2(DEPTH) bits, wrap naturally modulo DEPTH.
- push_b = in_valid[b] & (count_b < DEPTH | pop_b); pop_b = grant[b] & out_valid[b].
- Push to a full bank without a same-cycle pop is dropped; count and contents unchanged.
- Grant while out_valid[b]=0 is ignored.
- count_b next = count_b + push_b − pop_b; never exceeds DEPTH, never underflows.
- out_valid[b] = (count_b ≠ 0); out_req/out_index present mem[rd_ptr] combinationally from registered storage (FWFT).
- Several banks may push on the same cycle; all take the shared in_req/in_index.
- flush: all counts and pointers to 0 next edge; overrides push and pop in that cycle. Storage contents need not be cleared.
- busy and almost_full are decoded from the registered count only (no combinational path from in_valid or grant).

## Timing
- Reset (rst high, asynchronous): count=0, pointers=0, so out_valid=0, busy=0, almost_full=0 (when AF_MARGIN < DEPTH). out_req/out_index are don't-care while out_valid=0; storage is not reset.
- Push at edge N into an empty bank: out_valid high and head data valid after edge N (latency 1 cycle).
- Pop at edge N: next entry is presented after edge N; out_valid drops after edge N if count was 1 and no push.
- Push and pop on the same edge at count=1: out_valid stays high and the head advances to the new entry.
- Push and pop on the same edge at count=DEPTH: accepted, count stays DEPTH, busy stays high.
- busy rises the cycle after the push that fills the bank; mapper must sample busy before asserting in_valid.
- rst asserted mid-operation: all banks empty immediately, with no glitching of outputs after release.

## Test plan
- Reset: hold rst 5 cycles with in_valid=all ones -> out_valid=0, busy=0, count=0 for all banks throughout.
- Fill bank 0 (DEPTH=4): push data 1..6 on consecutive cycles, grant=0 -> count0=4, busy[0]=1 after the 4th push, data 5 and 6 dropped, almost_full[0]=1 from count 3; then grant for 4 cycles -> out_req data 1,2,3,4 in order, then out_valid[0]=0.
- Full with simultaneous push/pop: bank 3 full with 1..4, push 5 with grant -> pops 1, count stays 4, later drain order 2,3,4,5.
- Wrap-around: 10 interleaved push/pop rounds on bank 7 at count 1–2 -> FIFO order preserved across pointer wrap, count never exceeds 2.
- Multi-bank: in_valid=16'h8001 with data 0xA -> banks 0 and 15 both hold 0xA, other banks stay empty; spurious grant on bank 5 -> no change.
- Flush: banks 0–3 holding 2 entries each, assert flush together with push on bank 0 -> all counts 0 next cycle, out_valid=0, push discarded.
